// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and the IF/ID bundle type for the MIPS instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int          DEFAULT_INST_NUM_BIT = 8;
  localparam logic [31:0] RESET_PC             = 32'h0000_0000;
  localparam logic [31:0] EXC_PC               = 32'h0000_0180;
  localparam logic [31:0] NOP_INST             = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: control from ID/hazard unit, ROM port and IF/ID outputs.
// All inputs are level signals sampled at the rising clock edge; there is no
// valid/ready handshake: redirect_valid/exc_valid are one-cycle strobes and
// stall holds the stage for as long as it is high.
interface if_fetch_stage_if #(
  parameter int Inst_Num_BIT = if_fetch_stage_pkg::DEFAULT_INST_NUM_BIT
);

  logic                    stall;
  logic                    redirect_valid;
  logic [31:0]             redirect_pc;
  logic                    exc_valid;
  logic [Inst_Num_BIT-1:0] inst_addr;
  logic [31:0]             inst_data;
  logic [31:0]             pc;
  logic                    id_valid;
  logic [31:0]             id_inst;
  logic [31:0]             id_pc;
  logic [31:0]             id_pc_plus4;
  logic                    fetch_exc;
  logic                    dbg_pending;
  logic [31:0]             dbg_pending_pc;

  modport slave (
    input  stall, redirect_valid, redirect_pc, exc_valid, inst_data,
    output inst_addr, pc, id_valid, id_inst, id_pc, id_pc_plus4, fetch_exc,
           dbg_pending, dbg_pending_pc
  );

  modport master (
    output stall, redirect_valid, redirect_pc, exc_valid, inst_data,
    input  inst_addr, pc, id_valid, id_inst, id_pc, id_pc_plus4, fetch_exc,
           dbg_pending, dbg_pending_pc
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush turns the slot into a bubble (pc fields held),
// hold freezes it, otherwise it loads the new fetch bundle.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.valid = 1'b0;
      q_d.inst  = NOP_INST;
    end else if (!hold_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select with pending redirect,
// IF/ID register. Optional fetch-address fault check under macro IF_ADDR_CHECK_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int          Inst_Num_BIT = DEFAULT_INST_NUM_BIT,
  parameter logic [31:0] RESET_PC     = if_fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC       = if_fetch_stage_pkg::EXC_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  if_fetch_stage_if.slave       bus
);

  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_ADDR_CHECK_EN
  // A word index beyond the ROM is the same as nonzero PC bits above the index.
  assign fetch_fault = (pc_q[1:0] != 2'b00) || ((pc_q >> (Inst_Num_BIT + 2)) != 32'd0);
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    pc_d         = pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    if (bus.exc_valid) begin
      pc_d      = EXC_PC;
      pending_d = 1'b0;
    end else if (bus.stall) begin
      if (bus.redirect_valid) begin
        pending_d    = 1'b1;
        pending_pc_d = bus.redirect_pc;
      end
    end else begin
      pending_d = 1'b0;
      if (bus.redirect_valid)  pc_d = bus.redirect_pc;
      else if (pending_q)      pc_d = pending_pc_q;
      else                     pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  always_comb begin
    if_id_d.valid    = !fetch_fault;
    if_id_d.inst     = fetch_fault ? NOP_INST : bus.inst_data;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .hold_i  (bus.stall),
    .flush_i (bus.exc_valid),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

`ifdef IF_ADDR_CHECK_EN
  logic fetch_exc_q, fetch_exc_d;

  // Travels with the IF/ID slot: holds across stall, cleared by exception flush.
  always_comb begin
    fetch_exc_d = fetch_exc_q;
    if (bus.exc_valid)   fetch_exc_d = 1'b0;
    else if (!bus.stall) fetch_exc_d = fetch_fault;
  end

  always_ff @(posedge clk) begin
    if (!reset) fetch_exc_q <= 1'b0;
    else        fetch_exc_q <= fetch_exc_d;
  end

  assign bus.fetch_exc = fetch_exc_q;
`else
  assign bus.fetch_exc = 1'b0;
`endif

  assign bus.inst_addr      = pc_q[Inst_Num_BIT+1:2];
  assign bus.pc             = pc_q;
  assign bus.id_valid       = if_id_q.valid;
  assign bus.id_inst        = if_id_q.inst;
  assign bus.id_pc          = if_id_q.pc;
  assign bus.id_pc_plus4    = if_id_q.pc_plus4;
  assign bus.dbg_pending    = pending_q;
  assign bus.dbg_pending_pc = pending_pc_q;

endmodule
